// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
// Forwarding and flush/stall decisions use the pre-edge EX/MEM contents.
module ex_mem_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic [DW-1:0] rd1_in,
   input  logic [DW-1:0] rd2_in,
   input  logic [DW-1:0] se_in,
   input  logic [DW-1:0] pc_in,
   input  logic [RW-1:0] rs_in,
   input  logic [RW-1:0] rt_in,
   input  logic [RW-1:0] rd_in,
   input  logic [7:0]    control_in,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_wdata,
   output logic [DW-1:0] alu_result_out,
   output logic [DW-1:0] store_data_out,
   output logic [RW-1:0] dest_out,
   output logic [DW-1:0] pc_out,
   output logic [3:0]    mem_ctrl_out,
   output logic          zero_out,
   output logic          ovf_out,
   output logic          valid_out
);

   logic [DW-1:0] alu_result_reg, store_data_reg, pc_reg;
   logic [RW-1:0] dest_reg;
   logic [3:0]    mem_ctrl_reg;
   logic          zero_reg, ovf_reg, valid_reg;

   logic [DW-1:0] alu_result_next;
   logic [RW-1:0] dest_next;
   logic          ovf_next;

   logic          reg_dst, alu_src;
   logic [1:0]    alu_op;
   logic [5:0]    funct;
   logic [4:0]    shamt;
   logic          exmem_fwd_ok;

   assign reg_dst = control_in[7];
   assign alu_src = control_in[6];
   assign alu_op  = control_in[5:4];
   assign funct   = se_in[5:0];
   assign shamt   = se_in[10:6];

   // Only a real, register-writing EX/MEM instruction targeting a nonzero register may forward.
   assign exmem_fwd_ok = valid_reg & mem_ctrl_reg[1] & (dest_reg != '0);

   // Index 0 resolves rs (operand A), index 1 resolves rt (operand B / store data).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic [RW-1:0] src_reg;
         logic [DW-1:0] src_val;
         logic [DW-1:0] fwd;

         assign src_reg = (gi == 0) ? rs_in  : rt_in;
         assign src_val = (gi == 0) ? rd1_in : rd2_in;

         always_comb begin
            fwd = src_val;
            if (exmem_fwd_ok && (dest_reg == src_reg))
               fwd = alu_result_reg;
            else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_reg))
               fwd = memwb_wdata;
         end
      end
   endgenerate

   logic [DW-1:0] op_a, rt_fwd, op_b;
   logic [DW-1:0] sum, diff;
   logic          add_ovf, sub_ovf, slt_bit;

   assign op_a    = g_fwd[0].fwd;
   assign rt_fwd  = g_fwd[1].fwd;
   assign op_b    = alu_src ? se_in : rt_fwd;
   assign sum     = op_a + op_b;
   assign diff    = op_a - op_b;
   assign add_ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1]  != op_a[DW-1]);
   assign sub_ovf = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);
   assign slt_bit = $signed(op_a) < $signed(op_b);

   always_comb begin
      alu_result_next = '0;
      ovf_next        = 1'b0;
      case (alu_op)
         2'b00: begin alu_result_next = sum;  ovf_next = add_ovf; end
         2'b01: begin alu_result_next = diff; ovf_next = sub_ovf; end
         2'b11: alu_result_next = {{(DW-1){1'b0}}, slt_bit};
         default: begin
            case (funct)
               6'b100000: begin alu_result_next = sum;  ovf_next = add_ovf; end
               6'b100010: begin alu_result_next = diff; ovf_next = sub_ovf; end
               6'b100100: alu_result_next = op_a & op_b;
               6'b100101: alu_result_next = op_a | op_b;
               6'b100111: alu_result_next = ~(op_a | op_b);
               6'b101010: alu_result_next = {{(DW-1){1'b0}}, slt_bit};
               6'b000000: alu_result_next = op_b << shamt;
               6'b000010: alu_result_next = op_b >> shamt;
               default:   alu_result_next = '0;
            endcase
         end
      endcase
   end

   assign dest_next = reg_dst ? rd_in : rt_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_reg <= '0;
         store_data_reg <= '0;
         dest_reg       <= '0;
         pc_reg         <= '0;
         mem_ctrl_reg   <= '0;
         zero_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         valid_reg      <= 1'b0;
      end else if (flush) begin
         mem_ctrl_reg   <= '0;
         zero_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         valid_reg      <= 1'b0;
      end else if (!stall) begin
         alu_result_reg <= alu_result_next;
         store_data_reg <= rt_fwd;
         dest_reg       <= dest_next;
         pc_reg         <= pc_in;
         mem_ctrl_reg   <= control_in[3:0];
         zero_reg       <= (alu_result_next == '0);
         ovf_reg        <= ovf_next;
         valid_reg      <= (control_in != 8'h00);
      end
   end

   assign alu_result_out = alu_result_reg;
   assign store_data_out = store_data_reg;
   assign dest_out       = dest_reg;
   assign pc_out         = pc_reg;
   assign mem_ctrl_out   = mem_ctrl_reg;
   assign zero_out       = zero_reg;
   assign ovf_out        = ovf_reg;
   assign valid_out      = valid_reg;

endmodule
